pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Hazard and sequencing controller for the five-stage RISC-V pipeline. It drives the enable and flush controls of the PC, IF/ID and ID/EX (decode) pipeline registers, and the bubble control of EX/MEM. It resolves three conditions:
- load-use hazards, with a one-cycle bubble;
- multi-cycle multiplies resident in EX, with a counter-driven stall;
- taken branch/JAL redirects, by flushing the wrong-path instructions.

It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MUL_LAT, 4, total cycles a MUL occupies EX; legal range 1..16.

Ports:
- clk_i  in  1  pipeline clock, rising edge.
- reset_i  in  1  reset; asynchronous, active-high.
- id_rs1_i  in  5  rs1 field of the instruction in ID.
- id_rs2_i  in  5  rs2 field of the instruction in ID.
- id_use_rs1_i  in  1  ID instruction reads rs1.
- id_use_rs2_i  in  1  ID instruction reads rs2.
- ex_mem_rd_i  in  1  Mem_Rd of the instruction in EX (decode register output).
- ex_reg_w_i  in  1  Reg_w of the instruction in EX.
- ex_rd_i  in  5  RegD of the instruction in EX.
- ex_mul_i  in  1  Mul of the instruction in EX.
- ex_redirect_i  in  1  taken branch or JAL resolved in EX this cycle.
- pc_en_o  out  1  PC load enable.
- if_id_en_o  out  1  IF/ID load enable.
- if_id_flush_o  out  1  IF/ID loads a NOP at the next edge.
- id_ex_en_o  out  1  decode register load enable (0 = hold).
- id_ex_flush_o  out  1  decode register loads all-zero controls (bubble).
- ex_mem_flush_o  out  1  EX/MEM loads a bubble.
- mul_busy_o  out  1  multiply stall in progress.
- stall_count_o  out  16  saturating count of cycles with pc_en_o=0.

## Operation
- FSM states: RUN, MUL_WAIT. There is a 4-bit down-counter cnt.
- All outputs except stall_count_o are combinational from the state, cnt and the inputs.
- Default outputs (no event): pc_en=1, if_id_en=1, id_ex_en=1, all flushes 0, mul_busy=0.

Load-use hazard (lu):
- Condition: ex_mem_rd_i & ex_reg_w_i & (ex_rd_i != 0) & ((id_use_rs1_i & id_rs1_i == ex_rd_i) | (id_use_rs2_i & id_rs2_i == ex_rd_i)).
- Response in RUN: pc_en=0, if_id_en=0, id_ex_flush=1.
- One cycle only. The load leaves EX at the next edge, so no state is needed.

Redirect:
- Applies in RUN when ex_redirect_i=1.
- Response: pc_en=1, if_id_flush=1, id_ex_flush=1.
- Redirect overrides lu.

Multiply, RUN with ex_mul_i=1 and MUL_LAT ≥ 2:
- Stall outputs: pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_flush=1, mul_busy=1.
- cnt loads MUL_LAT-2; next state is MUL_WAIT.
- The mul stall overrides lu (ID/EX is held, so no bubble is inserted).

Multiply, MUL_WAIT:
- cnt != 0: stall outputs as above; cnt decrements.
- cnt == 0: default outputs (the MUL advances); next state is RUN.
- ex_redirect_i and lu are ignored in MUL_WAIT.

Multiply, MUL_LAT = 1:
- ex_mul_i is ignored; the FSM never leaves RUN.

Back-to-back MULs:
- The next MUL enters EX on the release edge. RUN then sees ex_mul_i=1 and restarts the sequence with no gap cycle.

stall_count_o:
- Increments at each edge where reset_i=0 and pc_en_o=0.
- Saturates at 16'hFFFF.

## Timing
- Reset (asynchronous, any time, including mid-multiply):
  - state=RUN, cnt=0, stall_count_o=0.
  - While reset_i=1, outputs are forced: pc_en=0, if_id_en=0, id_ex_en=0, if_id_flush=0, id_ex_flush=0, ex_mem_flush=0, mul_busy=0.
  - Defaults apply from the first cycle after release.
- Control latency: zero cycles. Outputs respond in the same cycle as their inputs, and registers act on the following rising edge.
- MUL with MUL_LAT=N:
  - Stall is asserted in EX-residency cycles 1..N-1 and released in cycle N.
  - In cycle k of residency in MUL_WAIT, cnt = N-k.
- Load-use costs exactly 1 cycle. Redirect costs 2 flushed slots.
- Only one of the lu, redirect and MUL conditions is legal in EX at a time. The priority order above resolves any illegal overlap deterministically: mul > redirect > lu.

## Test plan
- Load-use: EX holds lw x5 (Mem_Rd=1, Reg_w=1, rd=5); ID add reads rs1=5.
  - Required: one cycle with pc_en=0, if_id_en=0, id_ex_flush=1, then defaults.
  - Required: stall_count_o = 1.
  - Repeat with rd=0: no stall.
- MUL, MUL_LAT=4: ex_mul_i=1 held.
  - Required: mul_busy=1, id_ex_en=0, ex_mem_flush=1 for exactly 3 cycles, release in the 4th.
  - Required: stall_count_o = 3.
- Back-to-back MULs, MUL_LAT=4.
  - Required: the stall pattern 1,1,1,0,1,1,1,0.
  - Required: no lost cycle between the two sequences.
- Redirect: ex_redirect_i=1 together with a matching lu condition.
  - Required: pc_en=1, if_id_flush=1, id_ex_flush=1, if_id_en=1.
- Reset mid-multiply: assert reset_i in MUL_WAIT with cnt=1, asynchronously between edges.
  - Required: outputs go to reset values immediately; stall_count_o = 0.
  - Required: after release, the state is RUN and defaults are present.
- Saturation: hold a permanent MUL stall with MUL_LAT=16 for more than 65535 stall cycles.
  - Required: stall_count_o stays at 16'hFFFF.
  - MUL_LAT=1: ex_mul_i=1 produces no stall.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the hazard controller and the five-stage pipeline datapath.
// The pipeline side drives the ID/EX observations; the controller returns the enables and flushes.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        id_use_rs1_i;
  logic        id_use_rs2_i;
  logic        ex_mem_rd_i;
  logic        ex_reg_w_i;
  logic [4:0]  ex_rd_i;
  logic        ex_mul_i;
  logic        ex_redirect_i;
  logic        pc_en_o;
  logic        if_id_en_o;
  logic        if_id_flush_o;
  logic        id_ex_en_o;
  logic        id_ex_flush_o;
  logic        ex_mem_flush_o;
  logic        mul_busy_o;
  logic [15:0] stall_count_o;

  modport master (
    output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
    output ex_mem_rd_i, ex_reg_w_i, ex_rd_i, ex_mul_i, ex_redirect_i,
    input  pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
    input  ex_mem_flush_o, mul_busy_o, stall_count_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
    input  ex_mem_rd_i, ex_reg_w_i, ex_rd_i, ex_mul_i, ex_redirect_i,
    output pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
    output ex_mem_flush_o, mul_busy_o, stall_count_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: load-use bubble, multi-cycle MUL stall, redirect flush,
// plus a saturating count of cycles in which the PC was held.
module pipeline_hazard_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [0:0] {RUN, MUL_WAIT} state_t;

  localparam bit          MUL_EN   = (MUL_LAT >= 2);
  localparam int          LOAD_I   = MUL_EN ? (MUL_LAT - 2) : 0;
  localparam logic [3:0]  CNT_LOAD = LOAD_I[3:0];

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        lu;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush, mul_busy;
  logic [15:0] stall_count;

  assign lu = hz.ex_mem_rd_i & hz.ex_reg_w_i & (hz.ex_rd_i != 5'd0) &
              ((hz.id_use_rs1_i & (hz.id_rs1_i == hz.ex_rd_i)) |
               (hz.id_use_rs2_i & (hz.id_rs2_i == hz.ex_rd_i)));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Priority in RUN is mul > redirect > load-use; MUL_WAIT only watches its countdown.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mul_busy     = 1'b0;
    if (reset_i) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      id_ex_en = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (MUL_EN && hz.ex_mul_i) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
            mul_busy     = 1'b1;
            cnt_nxt      = CNT_LOAD;
            state_nxt    = MUL_WAIT;
          end else if (hz.ex_redirect_i) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (lu) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        MUL_WAIT: begin
          if (cnt != 4'd0) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
            mul_busy     = 1'b1;
            cnt_nxt      = cnt - 4'd1;
          end else begin
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_count <= 16'd0;
    end else if (!pc_en && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

  assign hz.pc_en_o        = pc_en;
  assign hz.if_id_en_o     = if_id_en;
  assign hz.if_id_flush_o  = if_id_flush;
  assign hz.id_ex_en_o     = id_ex_en;
  assign hz.id_ex_flush_o  = id_ex_flush;
  assign hz.ex_mem_flush_o = ex_mem_flush;
  assign hz.mul_busy_o     = mul_busy;
  assign hz.stall_count_o  = stall_count;

endmodule
